// File: rtl/completion_link_buffer.sv
// Store-and-forward completion buffer for one link lane: frames TLPs from header DW0
// and exposes only fully written packets on a valid/ready stream.
module completion_link_buffer #(
  parameter int LINK_ID     = 0,
  parameter int DEPTH       = 64,
  parameter int FULL_MARGIN = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     write_i,
  input  logic [1:0]               link_number_i,
  input  logic [31:0]              in_data_i,
  output logic                     output_buffer_full_o,
  output logic                     overflow_err_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [31:0]              out_data_o,
  output logic                     out_sop_o,
  output logic                     out_eop_o,
  output logic [$clog2(DEPTH):0]   pkt_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
  localparam logic [PW-1:0] FULL_THR = PW'(DEPTH - FULL_MARGIN);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DROP} state_e;

  state_e          state_q, state_d;
  logic [1:0]      hcnt_q, hcnt_d;
  logic [10:0]     rem_q, rem_d;
  logic [10:0]     len_q, len_d;
  logic            has_pl_q, has_pl_d;
  logic [PW-1:0]   wr_spec_q, wr_spec_d;
  logic [PW-1:0]   wr_commit_q, wr_commit_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   pkt_count_q, pkt_count_d;
  logic            obf_q, obf_d;
  logic            overflow_q, overflow_d;
  logic [33:0]     mem_q [DEPTH];

  logic            accept_s, full_s, ovf_s, mem_we_s, commit_s;
  logic            out_valid_s, hs_s, eop_rd_s;
  logic [33:0]     mem_wdata_s, rd_entry_s;
  logic [10:0]     dw0_len_s, pl_len_s, drop_rem_s;
  logic [PW-1:0]   occ_d_s;

  assign accept_s    = write_i && (link_number_i == 2'(LINK_ID));
  assign full_s      = (wr_spec_q - rd_ptr_q) == DEPTH_P;
  assign ovf_s       = accept_s && full_s && (state_q != S_DROP);
  assign dw0_len_s   = (in_data_i[9:0] == 10'd0) ? 11'd1024 : {1'b0, in_data_i[9:0]};
  assign pl_len_s    = has_pl_q ? len_q : 11'd0;
  assign rd_entry_s  = mem_q[rd_ptr_q[AW-1:0]];
  assign out_valid_s = (pkt_count_q != '0);
  assign hs_s        = out_valid_s && out_ready_i;
  assign eop_rd_s    = hs_s && rd_entry_s[32];

  // Write-side framing FSM and pointer next-state
  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    rem_d       = rem_q;
    len_d       = len_q;
    has_pl_d    = has_pl_q;
    mem_we_s    = 1'b0;
    mem_wdata_s = 34'd0;
    commit_s    = 1'b0;
    drop_rem_s  = 11'd0;
    case (state_q)
      S_IDLE: begin
        // Dwords left in a dropped packet after the offending one
        drop_rem_s = 11'd2 + (in_data_i[30] ? dw0_len_s : 11'd0);
        if (accept_s && !full_s) begin
          mem_we_s    = 1'b1;
          mem_wdata_s = {1'b1, 1'b0, in_data_i};
          len_d       = dw0_len_s;
          has_pl_d    = in_data_i[30];
          hcnt_d      = 2'd1;
          state_d     = S_HDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HDR: begin
        drop_rem_s = ((hcnt_q == 2'd1) ? 11'd1 : 11'd0) + pl_len_s;
        if (accept_s && !full_s) begin
          mem_we_s = 1'b1;
          if (hcnt_q == 2'd1) begin
            mem_wdata_s = {2'b00, in_data_i};
            hcnt_d      = 2'd2;
          end else if (has_pl_q) begin
            mem_wdata_s = {2'b00, in_data_i};
            rem_d       = len_q;
            state_d     = S_PAYLOAD;
          end else begin
            mem_wdata_s = {2'b01, in_data_i};
            commit_s    = 1'b1;
            state_d     = S_IDLE;
          end
        end else begin
          state_d = S_HDR;
        end
      end
      S_PAYLOAD: begin
        drop_rem_s = rem_q - 11'd1;
        if (accept_s && !full_s) begin
          mem_we_s    = 1'b1;
          mem_wdata_s = {1'b0, (rem_q == 11'd1), in_data_i};
          rem_d       = rem_q - 11'd1;
          commit_s    = (rem_q == 11'd1);
          state_d     = (rem_q == 11'd1) ? S_IDLE : S_PAYLOAD;
        end else begin
          state_d = S_PAYLOAD;
        end
      end
      S_DROP: begin
        if (accept_s) begin
          rem_d   = rem_q - 11'd1;
          state_d = (rem_q == 11'd1) ? S_IDLE : S_DROP;
        end else begin
          state_d = S_DROP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ovf_s) begin
      rem_d   = drop_rem_s;
      state_d = (drop_rem_s == 11'd0) ? S_IDLE : S_DROP;
    end else begin
      rem_d = rem_d;
    end
  end

  // Pointer, packet-count and back-pressure next-state
  always_comb begin
    overflow_d  = ovf_s;
    wr_spec_d   = ovf_s ? wr_commit_q : (wr_spec_q + PW'(mem_we_s));
    wr_commit_d = commit_s ? (wr_spec_q + 1'b1) : wr_commit_q;
    rd_ptr_d    = rd_ptr_q + PW'(hs_s);
    pkt_count_d = pkt_count_q + PW'(commit_s) - PW'(eop_rd_s);
    occ_d_s     = wr_spec_d - rd_ptr_d;
    obf_d       = (occ_d_s > FULL_THR);
  end

  // State and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hcnt_q      <= 2'd0;
      rem_q       <= 11'd0;
      len_q       <= 11'd0;
      has_pl_q    <= 1'b0;
      wr_spec_q   <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      pkt_count_q <= '0;
      obf_q       <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      rem_q       <= rem_d;
      len_q       <= len_d;
      has_pl_q    <= has_pl_d;
      wr_spec_q   <= wr_spec_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_count_q <= pkt_count_d;
      obf_q       <= obf_d;
      overflow_q  <= overflow_d;
    end
  end

  // Dword storage; contents are only visible once committed
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_spec_q[AW-1:0]] <= mem_wdata_s;
    end
  end

  assign output_buffer_full_o = obf_q;
  assign overflow_err_o       = overflow_q;
  assign out_valid_o          = out_valid_s;
  assign out_data_o           = out_valid_s ? rd_entry_s[31:0] : 32'd0;
  assign out_sop_o            = out_valid_s && rd_entry_s[33];
  assign out_eop_o            = out_valid_s && rd_entry_s[32];
  assign pkt_count_o          = pkt_count_q;

endmodule

// File: tb/tb_completion_link_buffer.sv
// Directed bench for completion_link_buffer (DEPTH=8, LINK_ID=2, FULL_MARGIN=4).
module tb_completion_link_buffer;

  logic        clk;
  logic        rst_n;
  logic        write_i;
  logic [1:0]  link_number_i;
  logic [31:0] in_data_i;
  logic        output_buffer_full_o;
  logic        overflow_err_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic        out_sop_o;
  logic        out_eop_o;
  logic [3:0]  pkt_count_o;

  int total = 0;
  int bad   = 0;

  completion_link_buffer #(.LINK_ID(2), .DEPTH(8), .FULL_MARGIN(4)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .write_i              (write_i),
    .link_number_i        (link_number_i),
    .in_data_i            (in_data_i),
    .output_buffer_full_o (output_buffer_full_o),
    .overflow_err_o       (overflow_err_o),
    .out_valid_o          (out_valid_o),
    .out_ready_i          (out_ready_i),
    .out_data_o           (out_data_o),
    .out_sop_o            (out_sop_o),
    .out_eop_o            (out_eop_o),
    .pkt_count_o          (pkt_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] lane, input logic [31:0] data);
    write_i       = 1'b1;
    link_number_i = lane;
    in_data_i     = data;
    tick();
    write_i       = 1'b0;
    in_data_i     = 32'd0;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] d, input logic s, input logic e);
    chk({tag, "_valid"}, 64'(out_valid_o), 64'd1);
    chk({tag, "_data"},  64'(out_data_o),  64'(d));
    chk({tag, "_sop"},   64'(out_sop_o),   64'(s));
    chk({tag, "_eop"},   64'(out_eop_o),   64'(e));
  endtask

  task automatic rd(input string tag, input logic [31:0] d, input logic s, input logic e);
    chk_out(tag, d, s, e);
    tick();
  endtask

  task automatic rd_bp(input string tag, input logic [31:0] d, input logic s, input logic e);
    out_ready_i = 1'b0;
    chk_out(tag, d, s, e);
    tick();
    chk({tag, "_hold"}, 64'(out_data_o), 64'(d));
    out_ready_i = 1'b1;
    tick();
  endtask

  task automatic wrrd(input logic [31:0] wdata, input string tag,
                      input logic [31:0] d, input logic s, input logic e);
    chk_out(tag, d, s, e);
    wr(2'd2, wdata);
  endtask

  logic [31:0] exp2 [7];
  logic [31:0] exp3 [7];

  initial begin
    exp2 = '{32'h4000_0004, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00B0,
             32'h0000_00B1, 32'h0000_00B2, 32'h0000_00B3};
    exp3 = '{32'h4000_0004, 32'h3333_0001, 32'h3333_0002, 32'h3333_00D0,
             32'h3333_00D1, 32'h3333_00D2, 32'h3333_00D3};
    rst_n = 1'b0; write_i = 1'b0; link_number_i = 2'd0; in_data_i = 32'd0; out_ready_i = 1'b0;
    tick(); tick();
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_data",  64'(out_data_o),  64'd0);
    chk("rst_obf",   64'(output_buffer_full_o), 64'd0);
    chk("rst_ovf",   64'(overflow_err_o), 64'd0);
    chk("rst_cnt",   64'(pkt_count_o), 64'd0);
    rst_n = 1'b1;
    tick();

    // header-only packet, first dword visible the cycle after DW2
    out_ready_i = 1'b1;
    wr(2'd2, 32'h0000_0000);
    chk("t1_v0", 64'(out_valid_o), 64'd0);
    wr(2'd2, 32'h1111_0001);
    chk("t1_v1", 64'(out_valid_o), 64'd0);
    wr(2'd2, 32'h2222_0002);
    chk("t1_cnt", 64'(pkt_count_o), 64'd1);
    rd("t1_d0", 32'h0000_0000, 1'b1, 1'b0);
    rd("t1_d1", 32'h1111_0001, 1'b0, 1'b0);
    rd("t1_d2", 32'h2222_0002, 1'b0, 1'b1);
    chk("t1_end_valid", 64'(out_valid_o), 64'd0);
    chk("t1_end_cnt",   64'(pkt_count_o), 64'd0);

    // payload packet interleaved with other lanes, drained under back-pressure
    out_ready_i = 1'b0;
    wr(2'd2, 32'h4000_0004);
    wr(2'd1, 32'h0000_0000);
    wr(2'd2, 32'h0000_00A1);
    wr(2'd3, 32'h4000_0009);
    wr(2'd2, 32'h0000_00A2);
    wr(2'd0, 32'h0000_BAD0);
    wr(2'd2, 32'h0000_00B0);
    wr(2'd2, 32'h0000_00B1);
    chk("t2_cnt_mid", 64'(pkt_count_o), 64'd0);
    wr(2'd1, 32'h0000_BAD1);
    wr(2'd2, 32'h0000_00B2);
    wr(2'd2, 32'h0000_00B3);
    chk("t2_cnt", 64'(pkt_count_o), 64'd1);
    chk("t2_obf", 64'(output_buffer_full_o), 64'd1);
    for (int i = 0; i < 7; i++) rd_bp("t2_d", exp2[i], (i == 0), (i == 6));
    chk("t2_end_cnt",   64'(pkt_count_o), 64'd0);
    chk("t2_end_valid", 64'(out_valid_o), 64'd0);
    chk("t2_end_data",  64'(out_data_o),  64'd0);

    // fill to full, overflow the second packet
    out_ready_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wr(2'd2, exp3[i]);
      if (i == 3) chk("t3_obf4", 64'(output_buffer_full_o), 64'd0);
      if (i == 4) chk("t3_obf5", 64'(output_buffer_full_o), 64'd1);
    end
    chk("t3_cnt_a", 64'(pkt_count_o), 64'd1);
    wr(2'd2, 32'h4000_0002);
    chk("t3_ovf_pre", 64'(overflow_err_o), 64'd0);
    wr(2'd2, 32'h0000_00C1);
    chk("t3_ovf", 64'(overflow_err_o), 64'd1);
    chk("t3_obf", 64'(output_buffer_full_o), 64'd1);
    wr(2'd2, 32'h0000_00C2);
    chk("t3_ovf_post", 64'(overflow_err_o), 64'd0);
    wr(2'd2, 32'h0000_00D0);
    wr(2'd2, 32'h0000_00D1);
    chk("t3_cnt", 64'(pkt_count_o), 64'd1);
    out_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) rd("t3_d", exp3[i], (i == 0), (i == 6));
    chk("t3_end_valid", 64'(out_valid_o), 64'd0);
    chk("t3_end_obf",   64'(output_buffer_full_o), 64'd0);

    // commit of B on the same edge as the eop read of A
    out_ready_i = 1'b0;
    wr(2'd2, 32'h0000_0010);
    wr(2'd2, 32'hA4A4_0001);
    wr(2'd2, 32'hA4A4_0002);
    chk("t4_cnt_a", 64'(pkt_count_o), 64'd1);
    out_ready_i = 1'b1;
    wrrd(32'h0000_0020, "t4_a0", 32'h0000_0010, 1'b1, 1'b0);
    wrrd(32'hB4B4_0001, "t4_a1", 32'hA4A4_0001, 1'b0, 1'b0);
    wrrd(32'hB4B4_0002, "t4_a2", 32'hA4A4_0002, 1'b0, 1'b1);
    chk("t4_cnt_same", 64'(pkt_count_o), 64'd1);
    rd("t4_b0", 32'h0000_0020, 1'b1, 1'b0);
    rd("t4_b1", 32'hB4B4_0001, 1'b0, 1'b0);
    rd("t4_b2", 32'hB4B4_0002, 1'b0, 1'b1);
    chk("t4_end_cnt", 64'(pkt_count_o), 64'd0);

    // reset with one committed packet and one partial packet buffered
    out_ready_i = 1'b0;
    wr(2'd2, 32'h0000_0030);
    wr(2'd2, 32'h0000_3001);
    wr(2'd2, 32'h0000_3002);
    wr(2'd2, 32'h4000_0001);
    wr(2'd2, 32'h0000_5001);
    chk("t5_obf_pre", 64'(output_buffer_full_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(out_valid_o), 64'd0);
    chk("t5_rst_data",  64'(out_data_o),  64'd0);
    chk("t5_rst_sop",   64'(out_sop_o),   64'd0);
    chk("t5_rst_eop",   64'(out_eop_o),   64'd0);
    chk("t5_rst_obf",   64'(output_buffer_full_o), 64'd0);
    chk("t5_rst_ovf",   64'(overflow_err_o), 64'd0);
    chk("t5_rst_cnt",   64'(pkt_count_o), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    out_ready_i = 1'b1;
    wr(2'd2, 32'h0000_0000);
    wr(2'd2, 32'h0000_F001);
    wr(2'd2, 32'h0000_F002);
    rd("t5_f0", 32'h0000_0000, 1'b1, 1'b0);
    rd("t5_f1", 32'h0000_F001, 1'b0, 1'b0);
    rd("t5_f2", 32'h0000_F002, 1'b0, 1'b1);
    chk("t5_end_valid", 64'(out_valid_o), 64'd0);
    chk("t5_end_cnt",   64'(pkt_count_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/completion_link_buffer.md
# completion_link_buffer

Per-link store-and-forward buffer directly downstream of the output link router. It captures the completion TLP dwords (3 header dwords plus an optional payload) that the router writes for one link lane, frames them from header DW0, and releases only complete packets to the link transmitter over a valid/ready stream. It drives the `output_buffer_full` back-pressure flag that the router samples before each write. One instance exists per link lane, so four per router.

## Interface
Parameters:
- `LINK_ID`, 0: link lane served; writes tagged with any other `link_number` are ignored.
- `DEPTH`, 64: FIFO depth in 32-bit dwords; power of 2, ≥ 8.
- `FULL_MARGIN`, 4: `output_buffer_full` asserts when free entries < `FULL_MARGIN`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `write`  in  1  router write strobe; one dword per cycle.
- `link_number`  in  2  lane tag of the current dword.
- `in_data`  in  32  header or payload dword, in packet order.
- `output_buffer_full`  out  1  back-pressure to router; registered.
- `overflow_err`  out  1  one-cycle pulse when a packet is dropped.
- `out_valid`  out  1  `out_data` holds a dword of a fully buffered packet.
- `out_ready`  in  1  transmitter accepts the dword when `out_valid` is also high.
- `out_data`  out  32  stream dword; 0 when `out_valid` is 0.
- `out_sop`  out  1  first dword of a packet.
- `out_eop`  out  1  last dword of a packet.
- `pkt_count`  out  $clog2(DEPTH)+1  number of committed packets not yet fully sent.

## Operation
- Accept rule: a dword is accepted when `write && link_number == LINK_ID`. Nothing else is stored.
- Storage: 34-bit entries `{sop, eop, data}`. The write side has two pointers:
  - `wr_spec` advances on every accepted dword.
  - `wr_commit` copies `wr_spec` when a packet's last dword is written.
  - The read side sees only `wr_commit`.
- Input FSM:
  - IDLE: the next accepted dword is DW0. Latch `len = in_data[9:0]` (0 means 1024) and `has_pl = in_data[30]`. Store it with sop=1. Go to HDR with `hcnt = 1`.
  - HDR: DW1 and DW2. After DW2, go to PAYLOAD if `has_pl`; otherwise store DW2 with eop=1, commit, and return to IDLE.
  - PAYLOAD: count down `len` dwords. The last one is stored with eop=1, then commit and return to IDLE.
  - DROP: discard accepted dwords until the dropped packet's computed length is exhausted, then return to IDLE. Nothing is stored.
- Overflow handling: if a dword is accepted while the FIFO is full (`wr_spec - rd_ptr == DEPTH`):
  - reset `wr_spec` to `wr_commit`;
  - pulse `overflow_err`;
  - enter DROP with the remaining count of that packet.
  - A packet longer than `DEPTH` therefore always drops.
- Read side:
  - `out_valid = (pkt_count != 0)`.
  - `out_data`, `out_sop` and `out_eop` come from `mem[rd_ptr]`.
  - On handshake, `rd_ptr++`.
  - On an eop handshake, `pkt_count--`.
- `pkt_count` update: it increments on commit. A commit and an eop handshake in the same cycle leave it unchanged.
- `output_buffer_full`: registered value of `(DEPTH - (wr_spec - rd_ptr)) < FULL_MARGIN`, computed from next-state pointers.
- Pointer arithmetic: pointers are `$clog2(DEPTH)+1` bits and wrap naturally. Occupancy is the modular difference of the pointers.

## Timing
- Reset (asynchronous assert, synchronous deassert use):
  - all pointers 0, FSM = IDLE, `pkt_count` 0;
  - `out_valid`, `out_sop`, `out_eop`, `out_data`, `output_buffer_full` and `overflow_err` all 0.
- Latency: when the last dword is written at edge N, `pkt_count` and `out_valid` rise after edge N, so the first dword is readable in cycle N+1.
- Throughput: one dword per cycle in and out simultaneously. Reading a packet while the next is being written is legal.
- `out_valid` never drops mid-packet, because only committed data is visible.
- `overflow_err` is high for exactly the cycle following the offending write edge.
- `output_buffer_full` lags occupancy by one cycle. `FULL_MARGIN` ≥ 2 covers the router's sample-to-write delay.
- A reset asserted mid-packet (either side) discards all contents, including partially written and partially read packets. There is no output glitch beyond the asynchronous clear.

## Test plan
- Header-only packet:
  - Stimulus: DW0 = 0x0000_0000 (bit30 = 0), DW1, DW2 with `link_number = LINK_ID`, `out_ready = 1`.
  - Response: 3 dwords out, sop on the first, eop on the third. `out_valid` first rises the cycle after DW2 is written.
- Payload packet with back-pressure:
  - Stimulus: DW0 = 0x4000_0004 (bit30 = 1, len = 4), 3 header + 4 payload dwords; `out_ready` toggles 1/0.
  - Response: 7 dwords in order, sop/eop on the first and seventh, no duplicates or skips, `pkt_count` returns to 0.
- Lane filter:
  - Stimulus: interleave writes tagged `link_number != LINK_ID`.
  - Response: those dwords are never output; the FSM count is unaffected.
- Full and overflow (DEPTH = 8):
  - Stimulus: `out_ready = 0`; write a len = 4 payload packet (7 dwords), then a len = 2 payload packet (5 dwords).
  - Response: `output_buffer_full` = 1 after the 5th dword. The second packet overflows: `overflow_err` pulses once, its remaining dwords are discarded, and `pkt_count` = 1. After draining, only the first packet appears.
- Simultaneous commit and eop read:
  - Stimulus: time the last write of packet B to coincide with the eop read of packet A.
  - Response: `pkt_count` stays 1, and B streams out next.
- Reset mid-packet:
  - Stimulus: drop `rst_n` after DW1 of a packet, release it, then send a fresh header-only packet.
  - Response: all outputs are 0 during reset, and only the fresh packet is output.
